paddle_conditioner: RTL and testbench

Conditions the two raw 8-bit potentiometer samples produced by the ADC interface block and turns them into stable 10-bit paddle Y coordinates for the game processor. It sits between the ADC interface and the Nios game logic. It detects each completed conversion from the ADC `busy` strobe and averages the last four samples per player. It then scales each average into the screen travel range and applies hysteresis so the paddles do not jitter on the VGA display.

---
 rtl/paddle_conditioner.sv | 166 ++++++++++++++++
 tb/tb_paddle_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/paddle_conditioner.sv
// Paddle conditioner: 4-sample average per player, scaled into screen Y, optional hysteresis.
// Define PADDLE_DEADBAND_EN to hold each paddle until it moves more than DEADBAND pixels.
module paddle_conditioner #(
  parameter int Y_MIN    = 40,
  parameter int Y_SPAN   = 400,
  parameter int DEADBAND = 2
) (
  input  logic       clock_50MHz,
  input  logic       RESET_n,
  input  logic       busy,
  input  logic [7:0] data_ad0,
  input  logic [7:0] data_ad1,
  output logic [9:0] p1y,
  output logic [9:0] p2y,
  output logic       upd,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, SCALE, HYST} state_t;

  localparam logic [17:0] SPAN18 = 18'(Y_SPAN);
  localparam logic [9:0]  YMIN10 = 10'(Y_MIN);

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic            busy_fall;
  logic            pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic            primed_q, primed_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0][7:0] hist0_q, hist0_d, hist1_q, hist1_d;
  logic [9:0]      sum0_q, sum0_d, sum1_q, sum1_d;
  logic [9:0]      tgt0_q, tgt0_d, tgt1_q, tgt1_d;
  logic [9:0]      p1y_q, p1y_d, p2y_q, p2y_d;
  logic            upd_q, upd_d;

  // The synchronizer carries inverted busy, so its all-ones reset state reads as "busy low"
  // and no edge can appear at reset release whatever level busy is sitting at.
  assign busy_fall = sync_q[1] & ~sync_q[2];

  function automatic logic [9:0] scale(input logic [9:0] sum);
    logic [17:0] prod;
    prod = {10'd0, sum[9:2]} * SPAN18;
    return YMIN10 + prod[17:8];
  endfunction

`ifdef PADDLE_DEADBAND_EN
  localparam logic [9:0] DB10 = 10'(DEADBAND);

  function automatic logic moves(input logic [9:0] tgt, input logic [9:0] cur);
    logic [9:0] diff;
    diff = (tgt >= cur) ? tgt - cur : cur - tgt;
    return diff > DB10;
  endfunction
`else
  logic unused_deadband;
  assign unused_deadband = (DEADBAND != 0);
`endif

  always_ff @(posedge clock_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q   <= 3'b111;
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      primed_q <= 1'b0;
      ptr_q    <= 2'd0;
      hist0_q  <= '0;
      hist1_q  <= '0;
      sum0_q   <= 10'd0;
      sum1_q   <= 10'd0;
      tgt0_q   <= YMIN10;
      tgt1_q   <= YMIN10;
      p1y_q    <= YMIN10;
      p2y_q    <= YMIN10;
      upd_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], ~busy};
      state_q  <= state_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      primed_q <= primed_d;
      ptr_q    <= ptr_d;
      hist0_q  <= hist0_d;
      hist1_q  <= hist1_d;
      sum0_q   <= sum0_d;
      sum1_q   <= sum1_d;
      tgt0_q   <= tgt0_d;
      tgt1_q   <= tgt1_d;
      p1y_q    <= p1y_d;
      p2y_q    <= p2y_d;
      upd_q    <= upd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    primed_d = primed_q;
    ptr_d    = ptr_q;
    hist0_d  = hist0_q;
    hist1_d  = hist1_q;
    sum0_d   = sum0_q;
    sum1_d   = sum1_q;
    tgt0_d   = tgt0_q;
    tgt1_d   = tgt1_q;
    p1y_d    = p1y_q;
    p2y_d    = p2y_q;
    upd_d    = 1'b0;

    // Busy edges seen while a pair is in flight queue one deep; a second one is lost.
    if (state_q != IDLE && busy_fall) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (busy_fall || pend_q) begin
          state_d = LOAD;
          pend_d  = busy_fall & pend_q;
        end
      end
      LOAD: begin
        state_d = SCALE;
        if (!primed_q) begin
          hist0_d  = {4{data_ad0}};
          hist1_d  = {4{data_ad1}};
          sum0_d   = {data_ad0, 2'b00};
          sum1_d   = {data_ad1, 2'b00};
          primed_d = 1'b1;
        end else begin
          hist0_d[ptr_q] = data_ad0;
          hist1_d[ptr_q] = data_ad1;
          sum0_d = sum0_q - {2'b00, hist0_q[ptr_q]} + {2'b00, data_ad0};
          sum1_d = sum1_q - {2'b00, hist1_q[ptr_q]} + {2'b00, data_ad1};
          ptr_d  = ptr_q + 2'd1;
        end
      end
      SCALE: begin
        state_d = HYST;
        tgt0_d  = scale(sum0_q);
        tgt1_d  = scale(sum1_q);
      end
      HYST: begin
        state_d = IDLE;
        upd_d   = 1'b1;
`ifdef PADDLE_DEADBAND_EN
        if (moves(tgt0_q, p1y_q)) p1y_d = tgt0_q;
        if (moves(tgt1_q, p2y_q)) p2y_d = tgt1_q;
`else
        p1y_d = tgt0_q;
        p2y_d = tgt1_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign p1y     = p1y_q;
  assign p2y     = p2y_q;
  assign upd     = upd_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_paddle_conditioner.sv
// Directed bench for paddle_conditioner: priming, averaging, hysteresis, pending/overrun, resets.
module tb_paddle_conditioner;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] d0, d1;
  logic [9:0] p1y, p2y;
  logic       upd, overrun;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  paddle_conditioner dut (
    .clock_50MHz(clk),
    .RESET_n    (rst_n),
    .busy       (busy),
    .data_ad0   (d0),
    .data_ad1   (d1),
    .p1y        (p1y),
    .p2y        (p2y),
    .upd        (upd),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One conversion: busy high long enough to settle, then a fall with fresh data.
  // upd is expected exactly on the 6th sampled negedge after the fall.
  task automatic conv(input logic [7:0] a0, input logic [7:0] a1,
                      input int e1, input int e2, input string tag);
    int hits;
    int at;
    hits = 0;
    at   = 0;
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    d0   = a0;
    d1   = a1;
    busy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (upd === 1'b1) begin
        hits++;
        at = k;
      end
    end
    chk({tag, " upd_count"}, hits, 1);
    chk({tag, " upd_cycle"}, at, 6);
    chk({tag, " p1y"}, {22'd0, p1y}, e1);
    chk({tag, " p2y"}, {22'd0, p2y}, e2);
  endtask

  // nfalls busy falls two cycles apart; reports upd count and first/last upd position.
  task automatic burst(input int nfalls, output int hits, output int first, output int last);
    hits  = 0;
    first = 0;
    last  = 0;
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    busy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (upd === 1'b1) begin
        hits++;
        if (first == 0) first = k;
        last = k;
      end
      if (k < 2 * nfalls - 1) busy = (k % 2 == 1);
    end
  endtask

  initial begin
    int db_exp[4];
    int avg_exp[4];
    int base;
    int hits, first, last;

`ifdef PADDLE_DEADBAND_EN
    db_exp = '{240, 240, 240, 240};
`else
    db_exp = '{240, 240, 240, 241};
`endif
    avg_exp = '{138, 238, 338, 438};

    clk   = 1'b0;
    rst_n = 1'b0;
    busy  = 1'b0;
    d0    = 8'd0;
    d1    = 8'd0;

    // Reset values, with busy held low through release.
    repeat (3) @(negedge clk);
    chk("reset p1y", {22'd0, p1y}, 40);
    chk("reset p2y", {22'd0, p2y}, 40);
    chk("reset upd", {31'd0, upd}, 0);
    chk("reset overrun", {31'd0, overrun}, 0);
    base  = upd_cnt;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("sync no false edge", upd_cnt - base, 0);

    // Priming and deadband sequence.
    conv(8'd128, 8'd0, 240, 40, "prime");
    for (int i = 0; i < 4; i++) conv(8'd129, 8'd0, db_exp[i], 40, $sformatf("deadband%0d", i));

    // Averaging from a zero-primed history.
    do_reset();
    conv(8'd0, 8'd100, 40, 196, "avg_prime");
    for (int i = 0; i < 4; i++) conv(8'd255, 8'd100, avg_exp[i], 196, $sformatf("avg%0d", i));

    // Reset during SCALE of an in-flight pair.
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    d0   = 8'd0;
    d1   = 8'd0;
    busy = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset p1y", {22'd0, p1y}, 40);
    chk("midreset p2y", {22'd0, p2y}, 40);
    chk("midreset upd", {31'd0, upd}, 0);
    base = upd_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset no upd", upd_cnt - base, 0);
    conv(8'd128, 8'd128, 240, 240, "reprime");

    // Second edge while busy processing is held pending.
    burst(2, hits, first, last);
    chk("pending upd_count", hits, 2);
    chk("pending first upd", first, 6);
    chk("pending second upd", last, 10);
    chk("pending overrun", {31'd0, overrun}, 0);

    // Fourth edge arrives with a pending edge already queued and is dropped.
    burst(4, hits, first, last);
    chk("overrun upd_count", hits, 3);
    chk("overrun first upd", first, 6);
    chk("overrun last upd", last, 14);
    chk("overrun set", {31'd0, overrun}, 1);
    repeat (20) @(negedge clk);
    chk("overrun sticky", {31'd0, overrun}, 1);
    do_reset();
    @(negedge clk);
    chk("overrun cleared", {31'd0, overrun}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
